mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the IF stage (instruction fetch)
//  and the MEM stage (load/store driven by the decoded MemRead/MemWrite).
//  Runs a request/done handshake on each side and a fixed-latency transaction on the port.
//  Produces per-stage stall outputs that the hazard logic ORs into pipeline freeze.
//  Sits between the pipeline stage registers and the memory macro.
// PARAMETERS
//  ADDR_W   32  address width, both requesters and the port
//  DATA_W   32  data width
//  MEM_LAT  2   cycles from the port_en cycle to the port_rdata-valid cycle; legal range >=1
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  if_req      in   1       fetch request; held until if_done
//  if_addr     in   ADDR_W  fetch address (PC)
//  if_done     out  1       1-cycle pulse; if_rdata valid in this cycle
//  if_rdata    out  DATA_W  fetched instruction
//  mem_req     in   1       data request (MemRead|MemWrite); held until mem_done
//  mem_we      in   1       1=store (MemWrite), 0=load (MemRead)
//  mem_addr    in   ADDR_W  ALU-computed address
//  mem_wdata   in   DATA_W  store data
//  mem_done    out  1       1-cycle pulse; load data valid / store committed
//  mem_rdata   out  DATA_W  load data
//  port_en     out  1       memory access strobe, exactly 1 cycle per transaction
//  port_we     out  1       memory write enable, qualified by port_en
//  port_addr   out  ADDR_W  memory address, registered
//  port_wdata  out  DATA_W  memory write data, registered
//  port_rdata  in   DATA_W  memory read data
//  stall_if    out  1       if_req & ~if_done
//  stall_mem   out  1       mem_req & ~mem_done
// BEHAVIOUR
//  - Reset values: FSM IDLE, counter 0, and all registered outputs 0 (port_en, port_we, port_addr, port_wdata, if_done, mem_done).
//    Stalls follow their equations. Reset mid-transaction aborts it: no done pulse, and the requester re-issues.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    * IDLE: when any req=1 at the clock edge, pick the owner, register addr/we/wdata, go to BUSY.
//    * BUSY: port_en=1 for its first cycle only (cycle G); the counter counts MEM_LAT cycles.
//    * RESP (cycle G+MEM_LAT): owner's done=1. Owner's rdata = port_rdata (combinational pass-through).
//      The non-owner's rdata holds its last value. Next state is IDLE.
//  - Latency: req seen in cycle R -> port_en in R+1 -> done in R+1+MEM_LAT.
//    The next grant is sampled in cycle R+2+MEM_LAT, giving one transaction per MEM_LAT+2 cycles.
//  - Handshake: a requester holds req, addr and data stable until its done.
//    Addr/data changes after grant are ignored (captured copy is used).
//    If req drops mid-transaction, the transaction still completes and done still pulses.
//  - Arbitration (default): fixed priority, MEM > IF when both req=1 in IDLE. MEM belongs to the older instruction.
//  - Store: port_we=1 with port_en. mem_done fires at G+MEM_LAT; mem_rdata is don't-care.
//  - At most one done per cycle, and never both.
//  - Counter width is $clog2(MEM_LAT+1). With MEM_LAT=1, BUSY lasts one cycle.
// CONFIGURATION
//  ARB_RR_EN defined: when both req=1 in IDLE, grant the side NOT granted last.
//    last_owner resets to IF, so the first tie goes to MEM. A lone requester always wins.
//  ARB_RR_EN undefined: fixed MEM > IF priority. No last_owner flop.
// STRUCTURE
//  Package mem_arb_pkg:
//    * typedef enum logic [1:0] arb_state_t {IDLE, BUSY, RESP}
//    * typedef enum logic owner_t {OWN_IF, OWN_MEM}
//  Sub-module mem_arb_lat_cnt: loadable down-counter (load MEM_LAT on grant, expire flag); instantiated once.
// TESTING
//  1. MEM_LAT=2, if_req=1, if_addr=0x100 at cycle 0, port_rdata=0x00500093 at cycle 3
//     -> port_en=1 and port_addr=0x100 only in cycle 1; if_done=1 and if_rdata=0x00500093 in cycle 3.
//  2. if_req and mem_req (load 0x2000) both rise in cycle 0
//     -> MEM granted first: mem_done in cycle 3, port_en for IF in cycle 5, if_done in cycle 7.
//     stall_if=1 in cycles 0-6.
//  3. Store mem_we=1, mem_addr=0x2004, mem_wdata=0xDEADBEEF
//     -> port_en=port_we=1 with that addr/data in cycle 1; mem_done in cycle 3; if_done stays 0.
//  4. reset asserted asynchronously in cycle 2 of a load
//     -> port_en, mem_done and if_done are 0 immediately; after release, re-issued req gets port_en 1 cycle later.
//  5. ARB_RR_EN: both req held continuously for 4 transactions
//     -> grant order MEM, IF, MEM, IF. Without the macro: MEM, MEM, ... while mem_req stays 1.
//  6. mem_req drops in cycle 2 after grant
//     -> mem_done still pulses in cycle 3; the FSM returns to IDLE in cycle 4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and arbitration helper for the IF/MEM memory port arbiter.
// Round-robin tie-breaking is enabled by defining ARB_RR_EN.

package mem_arb_pkg;

    // Port transaction phases: wait for a request, run the fixed latency, answer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Which pipeline stage currently owns the memory port.
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Grant decision. A lone requester always wins; on a tie the MEM stage wins
    // unless rotation is enabled, in which case the side not granted last wins.
    function automatic owner_t arb_pick(
        input logic   if_req,
        input logic   mem_req,
        input owner_t last_owner,
        input logic   rr_en
    );
        if (if_req && mem_req && rr_en) begin
            return (last_owner == OWN_IF) ? OWN_MEM : OWN_IF;
        end
        return mem_req ? OWN_MEM : OWN_IF;
    endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter timing the fixed memory latency of one port transaction.
// Loaded with MEM_LAT on grant, decremented once per BUSY cycle; expire_o flags
// the last BUSY cycle (count == 1).

module mem_arb_lat_cnt #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);

    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement, and the count never wraps below zero.
    always_comb begin
        // NOTE: assigning a default first means every path drives cnt_d, so no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == ONE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the IF stage and the
// MEM stage. One fixed-latency transaction runs at a time (IDLE -> BUSY -> RESP),
// each side sees a one-cycle done pulse, and per-stage stalls feed the hazard logic.
// Optional macro ARB_RR_EN: alternate the grant on ties instead of fixed MEM > IF.

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    // instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    // load/store side
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    // memory macro port
    output logic              port_en,
    output logic              port_we,
    output logic [ADDR_W-1:0] port_addr,
    output logic [DATA_W-1:0] port_wdata,
    input  logic [DATA_W-1:0] port_rdata,
    // pipeline freeze
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_t        state_q,      state_d;
    owner_t            owner_q,      owner_d;
    logic              port_en_q,    port_en_d;
    logic              port_we_q,    port_we_d;
    logic [ADDR_W-1:0] port_addr_q,  port_addr_d;
    logic [DATA_W-1:0] port_wdata_q, port_wdata_d;
    logic              if_done_q,    if_done_d;
    logic              mem_done_q,   mem_done_d;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;

    logic   grant;
    owner_t grant_owner;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_expire;

    // A new transaction can only start from IDLE; requests in BUSY/RESP wait.
    assign grant = (state_q == IDLE) && (if_req || mem_req);

`ifdef ARB_RR_EN
    owner_t last_owner_q;

    assign grant_owner = arb_pick(if_req, mem_req, last_owner_q, 1'b1);

    // Remember who was granted last; starting at IF hands the first tie to MEM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWN_IF;
        end else if (grant) begin
            last_owner_q <= grant_owner;
        end
    end
`else
    assign grant_owner = arb_pick(if_req, mem_req, OWN_IF, 1'b0);
`endif

    mem_arb_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load_i   (cnt_load),
        .dec_i    (cnt_dec),
        .expire_o (cnt_expire)
    );

    // Transaction FSM: capture the winner's request, strobe the port once, then answer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        port_en_d    = 1'b0;
        port_we_d    = 1'b0;
        port_addr_d  = port_addr_q;
        port_wdata_d = port_wdata_q;
        if_done_d    = 1'b0;
        mem_done_d   = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d   = grant_owner;
                    port_en_d = 1'b1;
                    cnt_load  = 1'b1;
                    state_d   = BUSY;
                    if (grant_owner == OWN_MEM) begin
                        port_we_d    = mem_we;
                        port_addr_d  = mem_addr;
                        port_wdata_d = mem_wdata;
                    end else begin
                        port_addr_d  = if_addr;
                    end
                end
            end
            BUSY: begin
                cnt_dec = 1'b1;
                if (cnt_expire) begin
                    state_d    = RESP;
                    if_done_d  = (owner_q == OWN_IF);
                    mem_done_d = (owner_q == OWN_MEM);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered port/done outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            port_en_q    <= 1'b0;
            port_we_q    <= 1'b0;
            port_addr_q  <= '0;
            port_wdata_q <= '0;
            if_done_q    <= 1'b0;
            mem_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            port_en_q    <= port_en_d;
            port_we_q    <= port_we_d;
            port_addr_q  <= port_addr_d;
            port_wdata_q <= port_wdata_d;
            if_done_q    <= if_done_d;
            mem_done_q   <= mem_done_d;
        end
    end

    // Keep each side's last read data so the non-owner's rdata stays stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (if_done_q) begin
                if_rdata_q <= port_rdata;
            end
            if (mem_done_q) begin
                mem_rdata_q <= port_rdata;
            end
        end
    end

    assign port_en    = port_en_q;
    assign port_we    = port_we_q;
    assign port_addr  = port_addr_q;
    assign port_wdata = port_wdata_q;
    assign if_done    = if_done_q;
    assign mem_done   = mem_done_q;

    // The owner sees memory data directly in its done cycle.
    assign if_rdata   = if_done_q  ? port_rdata : if_rdata_q;
    assign mem_rdata  = mem_done_q ? port_rdata : mem_rdata_q;

    assign stall_if   = if_req  & ~if_done_q;
    assign stall_mem  = mem_req & ~mem_done_q;

endmodule
